// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one load/store at a time, four byte-lane
// banks, raw word returned after WAIT_CYCLES wait states with a one-cycle ack.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic [31:0] rdata,
  output logic [7:0]  lane3,
  output logic [7:0]  lane2,
  output logic [7:0]  lane1,
  output logic [7:0]  lane0
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_latch;
  logic               w_access;
  logic [3:0]         r_be;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               w_oor;
  logic [ADDR_W-1:0]  w_idx;
  logic [31:0]        w_word;
  logic               w_unused;

  assign w_oor    = |r_addr[31:ADDR_W+2];
  assign w_idx    = r_addr[ADDR_W+1:2];
  assign w_unused = &{1'b0, r_addr[1:0]};

  // Next-state logic; ACK with req still high chains straight into the next transaction
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_latch    = 1'b0;
    w_access   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_latch    = 1'b1;
          w_cnt_next = CNT_W'(WAIT_CYCLES);
          w_next     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end else begin
          w_access = 1'b1;
          w_next   = S_ACK;
        end
      end
      S_ACK: begin
        if (req) begin
          w_latch    = 1'b1;
          w_cnt_next = CNT_W'(WAIT_CYCLES);
          w_next     = S_WAIT;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, counter and registered status outputs
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      rdata   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      ack     <= (w_next == S_ACK);
      busy    <= (w_next != S_IDLE);
      err     <= w_access && w_oor;
      if (w_access) begin
        rdata <= w_oor ? 32'd0 : w_word;
      end
    end
  end

  // Request capture; later input changes cannot disturb the transaction in flight
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_be    <= be;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  // Lane banks: written lanes take new data, others read back stored bytes (write-first)
  for (genvar n = 0; n < 4; n++) begin : g_lane
    logic [7:0] r_bank [DEPTH];

    // Bank write on the access edge for in-range requests only
    always_ff @(posedge clk) begin
      if (w_access && !w_oor && r_be[n]) begin
        r_bank[w_idx] <= r_wdata[8*n +: 8];
      end
    end

    assign w_word[8*n +: 8] = r_be[n] ? r_wdata[8*n +: 8] : r_bank[w_idx];
  end

  assign lane3 = rdata[31:24];
  assign lane2 = rdata[23:16];
  assign lane1 = rdata[15:8];
  assign lane0 = rdata[7:0];

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a WAIT_CYCLES=1 instance plus
// back-to-back, mid-transaction reset and zero-wait sequences.
module tb_dmem_responder;

  typedef struct {
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [1:0]  busy;
  logic [31:0] rdata [2];
  logic [7:0]  lane  [2][4];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Instance 0: zero wait states; instance 1: one wait state
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .clrn(clrn), .req(req[0]), .be(be), .addr(addr), .wdata(wdata),
    .ack(ack[0]), .err(err[0]), .busy(busy[0]), .rdata(rdata[0]),
    .lane3(lane[0][3]), .lane2(lane[0][2]), .lane1(lane[0][1]), .lane0(lane[0][0])
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .clrn(clrn), .req(req[1]), .be(be), .addr(addr), .wdata(wdata),
    .ack(ack[1]), .err(err[1]), .busy(busy[1]), .rdata(rdata[1]),
    .lane3(lane[1][3]), .lane2(lane[1][2]), .lane1(lane[1][1]), .lane0(lane[1][0])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One isolated transaction on instance sel with latency, data, lane and hold checks
  task automatic txn(input int sel, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_lat);
    int lat;
    req[sel] = 1'b1;
    be       = b;
    addr     = a;
    wdata    = d;
    @(posedge clk); #1;
    req[sel] = 1'b0;
    be       = 4'($urandom);
    addr     = $urandom;
    wdata    = $urandom;
    lat      = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (ack[sel]) begin
        lat = c;
        break;
      end
    end
    chk("ack_latency", 32'(lat), 32'(exp_lat));
    chk("rdata", rdata[sel], exp_rd);
    chk("lanes", {lane[sel][3], lane[sel][2], lane[sel][1], lane[sel][0]}, exp_rd);
    chk("err", 32'(err[sel]), 32'(exp_err));
    @(posedge clk); #1;
    chk("ack_width", 32'(ack[sel]), 32'd0);
    chk("busy_after", 32'(busy[sel]), 32'd0);
    chk("rdata_hold", rdata[sel], exp_rd);
  endtask

  vec_t vt [13];

  logic [3:0]  bb_be   [4];
  logic [31:0] bb_wd   [4];
  logic [31:0] bb_exp  [4];

  initial begin
    vt[0]  = '{4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vt[1]  = '{4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0};
    vt[2]  = '{4'h2, 32'h0000_0013, 32'h0000_1200, 32'hDEAD_12EF, 1'b0};
    vt[3]  = '{4'h0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_12EF, 1'b0};
    vt[4]  = '{4'hF, 32'h0000_0000, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
    vt[5]  = '{4'hF, 32'h0000_1000, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vt[6]  = '{4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0BAD_F00D, 1'b0};
    vt[7]  = '{4'hF, 32'h0000_0008, 32'h1122_3344, 32'h1122_3344, 1'b0};
    vt[8]  = '{4'h9, 32'h0000_0008, 32'hAABB_CCDD, 32'hAA22_33DD, 1'b0};
    vt[9]  = '{4'hF, 32'h0000_0FFC, 32'h5A5A_A5A5, 32'h5A5A_A5A5, 1'b0};
    vt[10] = '{4'h0, 32'h0000_0FFF, 32'h0000_0000, 32'h5A5A_A5A5, 1'b0};
    vt[11] = '{4'hF, 32'h8000_0FFC, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vt[12] = '{4'h0, 32'h0000_0FFC, 32'h0000_0000, 32'h5A5A_A5A5, 1'b0};

    bb_be[0] = 4'hF; bb_wd[0] = 32'h0102_0304; bb_exp[0] = 32'h0102_0304;
    bb_be[1] = 4'h0; bb_wd[1] = 32'h0000_0000; bb_exp[1] = 32'h0102_0304;
    bb_be[2] = 4'hF; bb_wd[2] = 32'hA0B0_C0D0; bb_exp[2] = 32'hA0B0_C0D0;
    bb_be[3] = 4'h0; bb_wd[3] = 32'hFFFF_FFFF; bb_exp[3] = 32'hA0B0_C0D0;

    // Reset values
    #22;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ack", 32'(ack[s]), 32'd0);
      chk("rst_err", 32'(err[s]), 32'd0);
      chk("rst_busy", 32'(busy[s]), 32'd0);
      chk("rst_rdata", rdata[s], 32'd0);
    end
    clrn = 1'b1;
    @(posedge clk); #1;

    // Table of isolated transactions, one wait state
    for (int i = 0; i < 13; i++) begin
      txn(1, vt[i].be, vt[i].addr, vt[i].wdata, vt[i].exp_rd, vt[i].exp_err, 2);
    end

    // Back-to-back with req held high: ack every 3 cycles, one cycle wide
    req[1] = 1'b1;
    be     = bb_be[0];
    addr   = 32'h0000_0020;
    wdata  = bb_wd[0];
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("b2b_ack_low", 32'(ack[1]), 32'd0);
      chk("b2b_busy", 32'(busy[1]), 32'd1);
      @(posedge clk); #1;
      chk("b2b_ack_high", 32'(ack[1]), 32'd1);
      chk("b2b_rdata", rdata[1], bb_exp[k]);
      chk("b2b_err", 32'(err[1]), 32'd0);
      if (k < 3) begin
        be    = bb_be[k+1];
        wdata = bb_wd[k+1];
      end else begin
        req[1] = 1'b0;
      end
      @(posedge clk);
    end
    #1;
    chk("b2b_end_ack", 32'(ack[1]), 32'd0);
    chk("b2b_end_busy", 32'(busy[1]), 32'd0);

    // Reset during WAIT discards the pending write
    req[1] = 1'b1;
    be     = 4'hF;
    addr   = 32'h0000_0010;
    wdata  = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req[1] = 1'b0;
    chk("mid_busy", 32'(busy[1]), 32'd1);
    #2 clrn = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack[1]), 32'd0);
    chk("mid_rst_busy", 32'(busy[1]), 32'd0);
    chk("mid_rst_rdata", rdata[1], 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("mid_rst_noack", 32'(ack[1]), 32'd0);
    clrn = 1'b1;
    @(posedge clk); #1;
    txn(1, 4'h0, 32'h0000_0010, 32'h0, 32'hDEAD_12EF, 1'b0, 2);

    // Zero wait states
    txn(0, 4'hF, 32'h0000_0004, 32'h7654_3210, 32'h7654_3210, 1'b0, 1);
    txn(0, 4'h0, 32'h0000_0004, 32'h0, 32'h7654_3210, 1'b0, 1);
    txn(0, 4'h4, 32'h0000_0006, 32'h00EE_0000, 32'h76EE_3210, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
